// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-schedule definitions.
//   NB         - words per round key / state column count
//   MAX_WORDS  - largest expanded key (AES-256), used for buffer sizing
//   ks_state_t - key scheduler control states
//   xtime, gf_mul, subword_operand - GF(2^8) and SubWord helpers
package aes_pkg;

  localparam int NB        = 4;
  localparam int MAX_WORDS = 60;

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_EXPAND = 2'd1,
    KS_SERVE  = 2'd2
  } ks_state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Word fed to the four S-boxes: RotWord is applied only on the i mod Nk == 0 step.
  function automatic logic [31:0] subword_operand(input logic [31:0] w, input logic rot);
    return rot ? {w[23:0], w[31:24]} : w;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box.
//   a - input byte
//   y - substituted byte
// Computed as multiplicative inverse (a^254) followed by the affine map,
// which avoids a 256-entry table; 0 maps to inverse 0 naturally.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  logic [7:0] sq;
  logic [7:0] inv;

  always_comb begin
    sq  = a;
    inv = 8'h01;
    // a^254 = a^2 * a^4 * ... * a^128
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_dec_key_sched.sv
// aes_dec_key_sched: sequential AES key expansion, round keys streamed Nr..0.
//   clk, rst_n           - clock, synchronous active-low reset
//   key_in, key_valid    - cipher key (w[0] in the top word), handshake in
//   key_ready            - high while idle
//   rk_out, rk_idx       - round key {w[4r]..w[4r+3]} and its round number
//   rk_valid, rk_ready   - round key handshake
//   rk_last              - marks round 0
//   busy                 - expanding or serving
//
// state  | meaning
// IDLE   | waiting for a key
// EXPAND | writing one expanded word per cycle, i = Nk .. 4(Nr+1)-1
// SERVE  | presenting round keys Nr down to 0
module aes_dec_key_sched
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [32*Nk-1:0] key_in,
  input  logic            key_valid,
  output logic            key_ready,
  output logic [127:0]    rk_out,
  output logic [3:0]      rk_idx,
  output logic            rk_valid,
  input  logic            rk_ready,
  output logic            rk_last,
  output logic            busy
);

  localparam int NW = NB * (Nr + 1);

  ks_state_t   state, state_nxt;
  logic [31:0] w [NW];
  logic [5:0]  i;
  logic [2:0]  imod;
  logic [7:0]  rcon;
  logic [31:0] w_prev, w_back, sb_in, sb_out, temp, new_word;
  logic [5:0]  rd_base;
  logic        accept, last_write;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= KS_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    key_ready = 1'b0;
    busy      = 1'b0;
    rk_valid  = 1'b0;
    case (state)
      KS_IDLE: begin
        key_ready = 1'b1;
        if (key_valid) state_nxt = KS_EXPAND;
      end
      KS_EXPAND: begin
        busy = 1'b1;
        if (i == 6'(NW - 1)) state_nxt = KS_SERVE;
      end
      KS_SERVE: begin
        busy     = 1'b1;
        rk_valid = 1'b1;
        if (rk_ready && rk_idx == 4'd0) state_nxt = KS_IDLE;
      end
      default: state_nxt = KS_IDLE;
    endcase
    rk_last = rk_valid && (rk_idx == 4'd0);
  end

  assign accept     = key_valid && key_ready;
  assign last_write = (state == KS_EXPAND) && (i == 6'(NW - 1));

  assign w_prev = w[i - 6'd1];
  assign w_back = w[i - 6'(Nk)];
  assign sb_in  = subword_operand(w_prev, imod == 3'd0);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a(sb_in[8*b +: 8]),
      .y(sb_out[8*b +: 8])
    );
  end

  always_comb begin
    temp = w_prev;
    if (imod == 3'd0)                temp = sb_out ^ {rcon, 24'h0};
    else if (Nk == 8 && imod == 3'd4) temp = sb_out;
  end

  assign new_word = w_back ^ temp;
  assign rd_base  = {rk_idx - 4'd1, 2'b00};

  // Buffer has no reset; contents are only read after a full expansion.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < Nk; k++) w[k] <= key_in[32*(Nk-1-k) +: 32];
    end else if (state == KS_EXPAND) begin
      w[i] <= new_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i      <= 6'd0;
      imod   <= 3'd0;
      rcon   <= 8'h00;
      rk_out <= 128'h0;
      rk_idx <= 4'd0;
    end else if (accept) begin
      i    <= 6'(Nk);
      imod <= 3'd0;
      rcon <= 8'h01;
    end else if (state == KS_EXPAND) begin
      i    <= i + 6'd1;
      imod <= (imod == 3'(Nk - 1)) ? 3'd0 : imod + 3'd1;
      if (imod == 3'd0) rcon <= xtime(rcon);
      // The final word is still in flight, so forward it into round key Nr.
      if (last_write) begin
        rk_out <= {w[NW-4], w[NW-3], w[NW-2], new_word};
        rk_idx <= 4'(Nr);
      end
    end else if (state == KS_SERVE && rk_ready && rk_idx != 4'd0) begin
      rk_idx <= rk_idx - 4'd1;
      rk_out <= {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
    end
  end

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// tb_aes_dec_key_sched: drives AES-128/192/256 instances of the key
// scheduler and checks every round key against a FIPS-197 style model.
module tb_aes_dec_key_sched;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [255:0] key_in   [3];
  logic         key_valid[3];
  logic         key_ready[3];
  logic [127:0] rk_out   [3];
  logic [3:0]   rk_idx   [3];
  logic         rk_valid [3];
  logic         rk_ready [3];
  logic         rk_last  [3];
  logic         busy     [3];

  aes_dec_key_sched #(.Nk(4), .Nr(10)) u_d128 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in[0][127:0]), .key_valid(key_valid[0]),
    .key_ready(key_ready[0]), .rk_out(rk_out[0]), .rk_idx(rk_idx[0]), .rk_valid(rk_valid[0]),
    .rk_ready(rk_ready[0]), .rk_last(rk_last[0]), .busy(busy[0]));

  aes_dec_key_sched #(.Nk(6), .Nr(12)) u_d192 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in[1][191:0]), .key_valid(key_valid[1]),
    .key_ready(key_ready[1]), .rk_out(rk_out[1]), .rk_idx(rk_idx[1]), .rk_valid(rk_valid[1]),
    .rk_ready(rk_ready[1]), .rk_last(rk_last[1]), .busy(busy[1]));

  aes_dec_key_sched #(.Nk(8), .Nr(14)) u_d256 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in[2]), .key_valid(key_valid[2]),
    .key_ready(key_ready[2]), .rk_out(rk_out[2]), .rk_idx(rk_idx[2]), .rk_valid(rk_valid[2]),
    .rk_ready(rk_ready[2]), .rk_last(rk_last[2]), .busy(busy[2]));

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb  [256];
  logic [127:0] rke [15];
  logic [127:0] first_rk, last_rk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Polynomial product then reduction by long division modulo 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = 15'h0;
    for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (15'(a) << k);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11b << (k - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0]  inv, s;
    logic [15:0] d;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ 8'h63;
      for (int k = 1; k <= 4; k++) begin
        d = {inv, inv} >> (8 - k);
        s = s ^ d[7:0];
      end
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic ref_expand(input int s, input logic [255:0] key);
    int          nk, nr;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    nk = 4 + 2 * s;
    nr = 10 + 2 * s;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*(nk-1-i) +: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rke[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [255:0] rnd_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_idle(input int s, input string tag);
    chk({tag, "_rk_valid"},  128'(rk_valid[s]),  128'd0);
    chk({tag, "_key_ready"}, 128'(key_ready[s]), 128'd1);
    chk({tag, "_busy"},      128'(busy[s]),      128'd0);
    chk({tag, "_rk_last"},   128'(rk_last[s]),   128'd0);
  endtask

  // abort_at >= 0: pulse reset after that many round keys have been taken.
  task automatic run_key(input int s, input logic [255:0] key, input bit stall,
                         input bit disturb, input int abort_at);
    int nk, nr, r, n, cyc;
    bit rdy, done, aborted;
    nk = 4 + 2 * s;
    nr = 10 + 2 * s;
    ref_expand(s, key);

    @(negedge clk);
    chk("key_ready_before_load", 128'(key_ready[s]), 128'd1);
    key_in[s]    = key;
    key_valid[s] = 1'b1;
    rk_ready[s]  = !stall;
    @(posedge clk);
    #1;
    key_valid[s] = 1'b0;
    key_in[s]    = ~key;

    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("busy_in_expand", 128'(busy[s]), 128'd1);
      if (disturb && n == 5) begin
        key_in[s]    = rnd_key();
        key_valid[s] = 1'b1;
      end
      if (n == 6) key_valid[s] = 1'b0;
      if (rk_valid[s]) break;
    end
    chk("expand_latency", 128'(n), 128'(4 * (nr + 1) - nk + 1));

    r = nr; cyc = 0; done = 0; aborted = 0;
    while (!done && cyc < 400) begin
      if (abort_at >= 0 && nr - r == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle(s, "after_reset");
        chk("after_reset_rk_out", rk_out[s], 128'h0);
        chk("after_reset_rk_idx", 128'(rk_idx[s]), 128'd0);
        aborted = 1;
        break;
      end
      chk("rk_valid_serve", 128'(rk_valid[s]), 128'd1);
      chk("rk_idx", 128'(rk_idx[s]), 128'(r));
      chk("rk_out", rk_out[s], rke[r]);
      chk("rk_last", 128'(rk_last[s]), 128'(r == 0));
      if (cyc == 0) first_rk = rk_out[s];
      if (r == 0)   last_rk  = rk_out[s];
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      rk_ready[s] = rdy;
      if (disturb && cyc == 2) begin
        key_in[s]    = rnd_key();
        key_valid[s] = 1'b1;
      end
      if (cyc == 3) key_valid[s] = 1'b0;
      @(negedge clk);
      cyc++;
      if (rdy) begin
        if (r == 0) done = 1;
        else        r--;
      end
    end
    rk_ready[s]  = 1'b0;
    key_valid[s] = 1'b0;
    if (!aborted) begin
      chk("serve_complete", 128'(done), 128'd1);
      if (!stall) chk("serve_cycles", 128'(cyc), 128'(nr + 1));
      check_idle(s, "after_last");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      key_in[s]    = '0;
      key_valid[s] = 1'b0;
      rk_ready[s]  = 1'b0;
    end
    build_sbox();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check_idle(s, "reset");
      chk("reset_rk_out", rk_out[s], 128'h0);
      chk("reset_rk_idx", 128'(rk_idx[s]), 128'd0);
    end
    rst_n = 1'b1;

    run_key(0, 256'h2b7e151628aed2a6abf7158809cf4f3c, 0, 0, -1);
    chk("aes128_first", first_rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("aes128_last", last_rk, 128'h2b7e151628aed2a6abf7158809cf4f3c);

    run_key(1, 256'h000102030405060708090a0b0c0d0e0f1011121314151617, 0, 0, -1);
    chk("aes192_first", first_rk, 128'ha4970a331a78dc09c418c271e3a41d5d);

    run_key(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 0, 0, -1);
    chk("aes256_first", first_rk, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    chk("aes256_last", last_rk, 128'h000102030405060708090a0b0c0d0e0f);

    run_key(0, 256'h2b7e151628aed2a6abf7158809cf4f3c, 1, 0, -1);

    for (int k = 0; k < 2; k++)
      for (int s = 0; s < 3; s++)
        run_key(s, rnd_key(), 1'(k), 1, -1);

    run_key(0, rnd_key(), 0, 0, 3);
    run_key(0, rnd_key(), 0, 0, -1);
    run_key(2, rnd_key(), 1, 1, 5);
    run_key(2, rnd_key(), 0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
